// File: rtl/btb_update_queue.sv
// BTB/bimodal training-write queue: turns c1 branch resolutions into BTB writes, buffered in a FIFO.
// Optional BTBQ_COALESCE_EN merges a candidate into the youngest queued entry when their vpc matches.
module btb_update_queue #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic              cpu_clock_i,
  input  logic              cpu_reset_i,
  input  logic              flush_i,
  input  logic              res_valid_i,
  input  logic              rcu_excp_i,
  input  logic              c1_btb_vld_i,
  input  logic [29:0]       c1_btb_vpc_i,
  input  logic [31:0]       c1_btb_target_i,
  input  logic [1:0]        c1_cntr_pred_i,
  input  logic              c1_bnch_tkn_i,
  input  logic [1:0]        c1_bnch_type_i,
  input  logic              c1_btb_way_i,
  input  logic              c1_btb_bm_mod_i,
  output logic              btb_wr_valid_o,
  input  logic              btb_wr_ready_i,
  output logic              btb_wr_full_o,
  output logic [29:0]       btb_wr_vpc_o,
  output logic [29:0]       btb_wr_target_o,
  output logic [1:0]        btb_wr_type_o,
  output logic              btb_wr_way_o,
  output logic [1:0]        btb_wr_cntr_o,
  output logic              q_full_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]        count_q, count_d;
  logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [DROP_W-1:0]  drop_q;

  logic               full_mem   [DEPTH];
  logic [29:0]        vpc_mem    [DEPTH];
  logic [29:0]        target_mem [DEPTH];
  logic [1:0]         type_mem   [DEPTH];
  logic               way_mem    [DEPTH];
  logic [1:0]         cntr_mem   [DEPTH];

  logic               cand_v, cand_full;
  logic [1:0]         cand_cntr, pred_inc, pred_dec;
  logic               pop, push, drop, coalesce;
  logic               unused_tgt_lsb;

  assign unused_tgt_lsb = ^c1_btb_target_i[1:0];

  assign pred_inc = (c1_cntr_pred_i == 2'b11) ? 2'b11 : c1_cntr_pred_i + 2'd1;
  assign pred_dec = (c1_cntr_pred_i == 2'b00) ? 2'b00 : c1_cntr_pred_i - 2'd1;

  always_comb begin
    cand_v    = 1'b0;
    cand_full = 1'b0;
    cand_cntr = 2'b00;
    if (res_valid_i && !flush_i) begin
      if (c1_bnch_tkn_i && (rcu_excp_i || !c1_btb_vld_i)) begin
        cand_v    = 1'b1;
        cand_full = 1'b1;
        cand_cntr = c1_btb_vld_i ? pred_inc : 2'b10;
      end else if (c1_bnch_tkn_i && c1_btb_bm_mod_i && c1_btb_vld_i) begin
        cand_v    = 1'b1;
        cand_cntr = pred_inc;
      end else if (!c1_bnch_tkn_i && c1_btb_vld_i && c1_bnch_type_i == 2'b00) begin
        cand_v    = 1'b1;
        cand_cntr = pred_dec;
      end
    end
  end

  assign pop = (count_q != '0) && btb_wr_ready_i;

`ifdef BTBQ_COALESCE_EN
  logic [PW-1:0] young_ptr;
  assign young_ptr = wr_ptr_q - 1'b1;
  // A lone entry leaving this cycle cannot absorb the candidate.
  assign coalesce  = cand_v && (count_q != '0) && (vpc_mem[young_ptr] == c1_btb_vpc_i)
                     && !((count_q == (PW+1)'(1)) && pop);
`else
  assign coalesce = 1'b0;
`endif

  assign push    = cand_v && !coalesce && ((count_q != (PW+1)'(DEPTH)) || pop);
  assign drop    = cand_v && !coalesce && !push;
  assign count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      drop_q   <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

  // Payload storage carries no reset; outputs are only meaningful while valid.
  always_ff @(posedge cpu_clock_i) begin
    if (push) begin
      full_mem[wr_ptr_q]   <= cand_full;
      vpc_mem[wr_ptr_q]    <= c1_btb_vpc_i;
      target_mem[wr_ptr_q] <= c1_btb_target_i[31:2];
      type_mem[wr_ptr_q]   <= c1_bnch_type_i;
      way_mem[wr_ptr_q]    <= c1_btb_way_i;
      cntr_mem[wr_ptr_q]   <= cand_cntr;
    end
`ifdef BTBQ_COALESCE_EN
    else if (coalesce) begin
      cntr_mem[young_ptr] <= cand_cntr;
      if (cand_full) begin
        full_mem[young_ptr]   <= 1'b1;
        target_mem[young_ptr] <= c1_btb_target_i[31:2];
        type_mem[young_ptr]   <= c1_bnch_type_i;
        way_mem[young_ptr]    <= c1_btb_way_i;
      end
    end
`endif
  end

  assign btb_wr_valid_o  = (count_q != '0);
  assign btb_wr_full_o   = full_mem[rd_ptr_q];
  assign btb_wr_vpc_o    = vpc_mem[rd_ptr_q];
  assign btb_wr_target_o = target_mem[rd_ptr_q];
  assign btb_wr_type_o   = type_mem[rd_ptr_q];
  assign btb_wr_way_o    = way_mem[rd_ptr_q];
  assign btb_wr_cntr_o   = cntr_mem[rd_ptr_q];
  assign q_full_o        = (count_q == (PW+1)'(DEPTH));
  assign drop_cnt_o      = drop_q;

endmodule

// File: tb/tb_btb_update_queue.sv
// Scoreboard bench for btb_update_queue: reference queue model plus an independent pop monitor.
module tb_btb_update_queue;
  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush, res_valid, excp, vld, tkn, way, bm_mod, ready;
  logic [29:0] vpc;
  logic [31:0] tgt;
  logic [1:0]  pred, btype;
  logic        wr_valid, wr_full, wr_way, q_full;
  logic [29:0] wr_vpc, wr_target;
  logic [1:0]  wr_type, wr_cntr;
  logic [DROP_W-1:0] drop_cnt;

  btb_update_queue #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .cpu_clock_i(clk), .cpu_reset_i(rst), .flush_i(flush), .res_valid_i(res_valid),
    .rcu_excp_i(excp), .c1_btb_vld_i(vld), .c1_btb_vpc_i(vpc), .c1_btb_target_i(tgt),
    .c1_cntr_pred_i(pred), .c1_bnch_tkn_i(tkn), .c1_bnch_type_i(btype), .c1_btb_way_i(way),
    .c1_btb_bm_mod_i(bm_mod), .btb_wr_valid_o(wr_valid), .btb_wr_ready_i(ready),
    .btb_wr_full_o(wr_full), .btb_wr_vpc_o(wr_vpc), .btb_wr_target_o(wr_target),
    .btb_wr_type_o(wr_type), .btb_wr_way_o(wr_way), .btb_wr_cntr_o(wr_cntr),
    .q_full_o(q_full), .drop_cnt_o(drop_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic        full;
    logic [29:0] vpc;
    logic [29:0] tgt;
    logic [1:0]  typ;
    logic        way;
    logic [1:0]  cntr;
  } ent_t;

  ent_t exp_q[$];
  int   drop_m = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] up(input logic [1:0] p);
    return (p == 2'd3) ? 2'd3 : p + 2'd1;
  endfunction

  function automatic logic [1:0] down(input logic [1:0] p);
    return (p == 2'd0) ? 2'd0 : p - 2'd1;
  endfunction

  // Reference model: evaluates each cycle's candidate against the expected queue contents.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      drop_m = 0;
      check("reset_valid", {63'd0, wr_valid}, 64'd0);
      check("reset_drop", {56'd0, drop_cnt}, 64'd0);
    end else begin
      bit   has, do_pop, merged;
      ent_t c;
      check("valid_vs_model", {63'd0, wr_valid}, {63'd0, exp_q.size() != 0});
      check("q_full", {63'd0, q_full}, {63'd0, exp_q.size() == DEPTH});
      check("drop_cnt", {56'd0, drop_cnt}, 64'(drop_m));
      do_pop = (exp_q.size() != 0) && ready;
      has = 1'b0;
      c.vpc = vpc; c.tgt = tgt[31:2]; c.typ = btype; c.way = way; c.full = 1'b0; c.cntr = 2'b00;
      if (res_valid && !flush) begin
        if (tkn && (excp || !vld)) begin
          has = 1'b1; c.full = 1'b1; c.cntr = vld ? up(pred) : 2'b10;
        end else if (tkn && bm_mod && vld) begin
          has = 1'b1; c.cntr = up(pred);
        end else if (!tkn && vld && btype == 2'b00) begin
          has = 1'b1; c.cntr = down(pred);
        end
      end
      merged = 1'b0;
`ifdef BTBQ_COALESCE_EN
      if (has && exp_q.size() != 0 && exp_q[$].vpc == c.vpc && !(exp_q.size() == 1 && do_pop)) begin
        merged = 1'b1;
        exp_q[$].cntr = c.cntr;
        if (c.full) begin
          exp_q[$].full = 1'b1; exp_q[$].tgt = c.tgt; exp_q[$].typ = c.typ; exp_q[$].way = c.way;
        end
      end
`endif
      if (has && !merged) begin
        if (exp_q.size() < DEPTH || do_pop) exp_q.push_back(c);
        else if (drop_m < 255) drop_m++;
      end
    end
  end

  // Monitor: every accepted BTB write must match the oldest expected entry.
  always @(negedge clk) begin
    #2;
    if (!rst && wr_valid && ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL pop_unexpected: got write vpc %0h expected none", wr_vpc);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        check("wr_full", {63'd0, wr_full}, {63'd0, e.full});
        check("wr_vpc", {34'd0, wr_vpc}, {34'd0, e.vpc});
        check("wr_target", {34'd0, wr_target}, {34'd0, e.tgt});
        check("wr_type", {62'd0, wr_type}, {62'd0, e.typ});
        check("wr_way", {63'd0, wr_way}, {63'd0, e.way});
        check("wr_cntr", {62'd0, wr_cntr}, {62'd0, e.cntr});
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    res_valid = 0; flush = 0; excp = 0; vld = 0; tkn = 0; bm_mod = 0; way = 0;
    pred = 2'b00; btype = 2'b00; vpc = '0; tgt = '0;
  endtask

  task automatic drive(input logic v, input logic tk, input logic x, input logic bm,
                       input logic [1:0] p, input logic [1:0] ty, input logic [29:0] pc,
                       input logic [31:0] t);
    res_valid = 1; flush = 0; vld = v; tkn = tk; excp = x; bm_mod = bm;
    pred = p; btype = ty; vpc = pc; tgt = t; way = pc[0];
  endtask

  task automatic pop_one();
    ready = 1; step(); ready = 0;
  endtask

  task automatic drain(input int budget);
    ready = 1;
    for (int i = 0; i < budget && wr_valid; i++) step();
    check("drain_done", {63'd0, wr_valid}, 64'd0);
    ready = 0;
  endtask

  initial begin
    int pops;
    idle(); ready = 0; rst = 1;
    step(); step();
    rst = 0;
    step();

    // Miss on a taken jal: full write one cycle later, never in the same cycle.
    drive(0, 1, 0, 0, 2'b01, 2'b10, 30'h100, 32'h800);
    check("no_bypass", {63'd0, wr_valid}, 64'd0);
    step(); idle();
    check("jal_valid", {63'd0, wr_valid}, 64'd1);
    check("jal_full", {63'd0, wr_full}, 64'd1);
    check("jal_type", {62'd0, wr_type}, 64'h2);
    check("jal_cntr", {62'd0, wr_cntr}, 64'h2);
    check("jal_target", {34'd0, wr_target}, 64'h200);

    drive(1, 0, 0, 0, 2'b00, 2'b00, 30'h101, 32'h404); step();
    drive(1, 1, 0, 1, 2'b11, 2'b00, 30'h102, 32'h408); step(); idle();
    pop_one();
    check("nt_full", {63'd0, wr_full}, 64'd0);
    check("nt_cntr", {62'd0, wr_cntr}, 64'h0);
    pop_one();
    check("bm_full", {63'd0, wr_full}, 64'd0);
    check("bm_cntr", {62'd0, wr_cntr}, 64'h3);
    pop_one();
    check("empty_after_pops", {63'd0, wr_valid}, 64'd0);

    // Overflow with the port stalled, then push and pop together while full.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 2'b00, 2'b10, 30'h200 + 30'(i), 32'h1000 + 32'(i * 4)); step();
    end
    idle(); step();
    check("ovf_full", {63'd0, q_full}, 64'd1);
    check("ovf_drop", {56'd0, drop_cnt}, 64'd1);
    drive(0, 1, 0, 0, 2'b00, 2'b10, 30'h210, 32'h2000); ready = 1; step();
    idle(); ready = 0; step();
    check("pushpop_full", {63'd0, q_full}, 64'd1);
    check("pushpop_drop", {56'd0, drop_cnt}, 64'd1);

    // Asynchronous reset with traffic queued.
    rst = 1; #1;
    check("rst_valid", {63'd0, wr_valid}, 64'd0);
    check("rst_qfull", {63'd0, q_full}, 64'd0);
    check("rst_drop", {56'd0, drop_cnt}, 64'd0);
    step(); rst = 0; step();
    check("post_rst_empty", {63'd0, wr_valid}, 64'd0);

    // Flush suppresses only the flushed cycle's candidate.
    drive(0, 1, 0, 0, 2'b00, 2'b10, 30'h300, 32'h3000); step();
    drive(1, 0, 0, 0, 2'b10, 2'b00, 30'h301, 32'h3004); step();
    drive(0, 1, 1, 0, 2'b00, 2'b10, 30'h302, 32'h3008); flush = 1; step();
    idle(); step();
    pops = 0; ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (wr_valid) pops++;
      step();
    end
    ready = 0;
    check("flush_pops", 64'(pops), 64'd2);

    // Two trainings of the same branch while stalled.
    drive(1, 1, 0, 1, 2'b01, 2'b00, 30'h140, 32'h500); step();
    drive(1, 1, 0, 1, 2'b10, 2'b00, 30'h140, 32'h500); step(); idle(); step();
`ifdef BTBQ_COALESCE_EN
    check("same_vpc_head_cntr", {62'd0, wr_cntr}, 64'h3);
`else
    check("same_vpc_head_cntr", {62'd0, wr_cntr}, 64'h2);
`endif
    pops = 0; ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (wr_valid) pops++;
      step();
    end
    ready = 0;
`ifdef BTBQ_COALESCE_EN
    check("same_vpc_count", 64'(pops), 64'd1);
`else
    check("same_vpc_count", 64'(pops), 64'd2);
`endif

    // Random traffic over a small vpc set so stalls, drops and repeats all occur.
    for (int i = 0; i < 3000; i++) begin
      res_valid = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 7) == 0);
      excp      = ($urandom_range(0, 3) == 0);
      vld       = $urandom_range(0, 1);
      tkn       = $urandom_range(0, 1);
      bm_mod    = $urandom_range(0, 1);
      way       = $urandom_range(0, 1);
      pred      = 2'($urandom_range(0, 3));
      btype     = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b10;
      vpc       = 30'h40 + 30'($urandom_range(0, 3));
      tgt       = $urandom;
      ready     = ($urandom_range(0, 2) == 0);
      step();
    end
    idle();
    drain(40);
    check("model_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
